// File: rtl/data_mem_bank_if.sv
// rtl/data_mem_bank_if.sv - request/response bus for the MEM-stage data memory bank
interface data_mem_bank_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        size;
  logic              sign_ext;
  logic [WORD_W-1:0] wdata;
  logic              ready;
  logic              rvalid;
  logic [WORD_W-1:0] rdata;
  logic              err;
  logic              init_done;

  modport master (
    output req, we, addr, size, sign_ext, wdata,
    input  ready, rvalid, rdata, err, init_done
  );

  modport slave (
    input  req, we, addr, size, sign_ext, wdata,
    output ready, rvalid, rdata, err, init_done
  );
endinterface

// File: rtl/data_mem_bank.sv
// rtl/data_mem_bank.sv - big-endian byte-addressable data memory with handshake, read latency and init sweep
module data_mem_bank #(
  parameter int WORD_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int BASE_ADDR   = 1024,
  parameter int RD_LAT      = 2
) (
  input  logic          clk,
  input  logic          rst,
  data_mem_bank_if.slave bus
);

  localparam int BPW    = WORD_W / 8;
  localparam int LANE_W = $clog2(BPW);
  localparam int IDX_W  = $clog2(DEPTH_WORDS);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(DEPTH_WORDS * BPW);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH_WORDS - 1);
  localparam logic [2:0]        LAT_LOAD = 3'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_RD_WAIT
  } state_t;

  state_t state_q, state_d;

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0]  sweep_idx;
  logic [2:0]        lat_cnt;

  // captured read request, consumed when the latency counter expires
  logic [IDX_W-1:0]  rd_idx;
  logic [LANE_W-1:0] rd_lane;
  logic [1:0]        rd_size;
  logic              rd_sext;
  logic              rd_bad;

  logic              rvalid_q;
  logic              err_q;
  logic [WORD_W-1:0] rdata_q;
  logic              init_done_q;

  // request decode
  logic [ADDR_W-1:0] off;
  logic              in_range;
  logic              aligned;
  logic              acc_ok;
  logic [LANE_W-1:0] lane;
  logic [IDX_W-1:0]  idx;

  logic [WORD_W-1:0] wr_mask;
  logic [WORD_W-1:0] wr_data;
  logic [WORD_W-1:0] wr_merged;
  logic [WORD_W-1:0] rd_shifted;
  logic [WORD_W-1:0] rd_val;

  // right-shift distance that brings the addressed lanes to the bottom of the word;
  // lane 0 is the most significant byte
  function automatic int lane_shift(input logic [1:0] sz, input logic [LANE_W-1:0] ln);
    int s;
    case (sz)
      2'b00:   s = (BPW - 1 - int'(ln)) * 8;
      2'b01:   s = (BPW - 2 - int'(ln)) * 8;
      default: s = 0;
    endcase
    if (s < 0) s = 0;
    return s;
  endfunction

  // address window check, alignment and lane merge for writes
  always_comb begin
    off      = bus.addr - BASE;
    in_range = (bus.addr >= BASE) && (off < SPAN);
    lane     = off[LANE_W-1:0];
    idx      = off[LANE_W +: IDX_W];
    case (bus.size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = (lane[0] == 1'b0);
      2'b10:   aligned = (lane == '0);
      default: aligned = 1'b0;
    endcase
    acc_ok = in_range && aligned;

    case (bus.size)
      2'b00: begin
        wr_mask = {{(WORD_W-8){1'b0}}, 8'hFF} << lane_shift(bus.size, lane);
        wr_data = {{(WORD_W-8){1'b0}}, bus.wdata[7:0]} << lane_shift(bus.size, lane);
      end
      2'b01: begin
        wr_mask = {{(WORD_W-16){1'b0}}, 16'hFFFF} << lane_shift(bus.size, lane);
        wr_data = {{(WORD_W-16){1'b0}}, bus.wdata[15:0]} << lane_shift(bus.size, lane);
      end
      default: begin
        wr_mask = '1;
        wr_data = bus.wdata;
      end
    endcase
    wr_merged = (mem[idx] & ~wr_mask) | (wr_data & wr_mask);
  end

  // extract and extend the captured read; bad requests answer with zero
  always_comb begin
    rd_shifted = mem[rd_idx] >> lane_shift(rd_size, rd_lane);
    case (rd_size)
      2'b00:   rd_val = {{(WORD_W-8){rd_sext & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   rd_val = {{(WORD_W-16){rd_sext & rd_shifted[15]}}, rd_shifted[15:0]};
      default: rd_val = rd_shifted;
    endcase
    if (rd_bad) rd_val = '0;
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_INIT;
    else      state_q <= state_d;
  end

  // next state and handshake output
  always_comb begin
    state_d   = state_q;
    bus.ready = 1'b0;
    case (state_q)
      S_INIT: begin
        if (sweep_idx == LAST_IDX) state_d = S_IDLE;
      end
      S_IDLE: begin
        bus.ready = 1'b1;
        if (bus.req && !bus.we) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_cnt == 3'd0) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  // sweep counter, request capture, latency countdown and response pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sweep_idx   <= '0;
      lat_cnt     <= '0;
      rd_idx      <= '0;
      rd_lane     <= '0;
      rd_size     <= '0;
      rd_sext     <= 1'b0;
      rd_bad      <= 1'b0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      init_done_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        S_INIT: begin
          sweep_idx <= sweep_idx + 1'b1;
          if (sweep_idx == LAST_IDX) init_done_q <= 1'b1;
        end
        S_IDLE: begin
          if (bus.req) begin
            if (bus.we) begin
              err_q <= !acc_ok;
            end else begin
              lat_cnt <= LAT_LOAD;
              rd_idx  <= idx;
              rd_lane <= lane;
              rd_size <= bus.size;
              rd_sext <= bus.sign_ext;
              rd_bad  <= !acc_ok;
            end
          end
        end
        S_RD_WAIT: begin
          if (lat_cnt == 3'd0) begin
            rvalid_q <= 1'b1;
            err_q    <= rd_bad;
            rdata_q  <= rd_val;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // storage: zero sweep while initialising, lane-merged writes when idle
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem[sweep_idx] <= '0;
    end else if (state_q == S_IDLE && bus.req && bus.we && acc_ok) begin
      mem[idx] <= wr_merged;
    end
  end

  assign bus.rvalid    = rvalid_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_data_mem_bank.sv
// tb/tb_data_mem_bank.sv - directed self-checking bench for data_mem_bank
module tb_data_mem_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  data_mem_bank_if #(.ADDR_W(32), .WORD_W(32)) bus ();

  data_mem_bank #(
    .WORD_W(32), .DEPTH_WORDS(256), .ADDR_W(32), .BASE_ADDR(1024), .RD_LAT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 400 && bus.ready !== 1'b1; i++) tick();
    if (bus.ready !== 1'b1) check("ready_timeout", {31'd0, bus.ready}, 32'd1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] d, output logic e);
    wait_ready();
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = a; bus.size = sz;
    bus.wdata = d; bus.sign_ext = 1'b0;
    tick();
    e = bus.err;
    bus.req = 1'b0; bus.we = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                         output logic [31:0] d, output logic e, output int lat);
    wait_ready();
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = a; bus.size = sz; bus.sign_ext = sx;
    tick();
    bus.req = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (bus.rvalid === 1'b1) begin
        lat = i;
        break;
      end
    end
    d = bus.rdata;
    e = bus.err;
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;
  int          busy;

  initial begin
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'd1024; bus.size = 2'b10;
    bus.sign_ext = 1'b0; bus.wdata = '0;

    repeat (3) tick();
    check("rst_ready", {31'd0, bus.ready}, 32'd0);
    check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_init_done", {31'd0, bus.init_done}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);

    rst = 1'b1;
    busy = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (bus.ready !== 1'b0 || bus.init_done !== 1'b0) busy++;
    end
    check("sweep_busy_cycles", busy, 0);
    tick();
    check("sweep_ready", {31'd0, bus.ready}, 32'd1);
    check("sweep_init_done", {31'd0, bus.init_done}, 32'd1);

    do_read(32'd1024, 2'b10, 1'b0, rd, e, lat);
    check("init_rd_data", rd, 32'h0000_0000);
    check("init_rd_lat", lat, 2);
    tick();
    check("rvalid_one_cycle", {31'd0, bus.rvalid}, 32'd0);

    do_write(32'd1024, 2'b10, 32'h1122_3344, e);
    check("wr_word_err", {31'd0, e}, 32'd0);
    do_read(32'd1025, 2'b00, 1'b0, rd, e, lat);
    check("rd_byte1025", rd, 32'h0000_0022);
    check("rd_byte1025_lat", lat, 2);
    check("rd_byte1025_err", {31'd0, e}, 32'd0);

    do_write(32'd1027, 2'b00, 32'h0000_0080, e);
    do_read(32'd1027, 2'b00, 1'b1, rd, e, lat);
    check("rd_byte1027_sx", rd, 32'hFFFF_FF80);
    do_read(32'd1024, 2'b10, 1'b0, rd, e, lat);
    check("rd_word_after_byte", rd, 32'h1122_3380);

    do_write(32'd1026, 2'b01, 32'h0000_BEEF, e);
    do_read(32'd1026, 2'b01, 1'b0, rd, e, lat);
    check("rd_half1026", rd, 32'h0000_BEEF);
    do_read(32'd1026, 2'b01, 1'b1, rd, e, lat);
    check("rd_half1026_sx", rd, 32'hFFFF_BEEF);
    do_read(32'd1024, 2'b01, 1'b1, rd, e, lat);
    check("rd_half1024_sx", rd, 32'h0000_1122);
    do_read(32'd1024, 2'b10, 1'b0, rd, e, lat);
    check("rd_word_after_half", rd, 32'h1122_BEEF);

    do_write(32'd1025, 2'b10, 32'hDEAD_BEEF, e);
    check("wr_misaligned_err", {31'd0, e}, 32'd1);
    tick();
    check("err_one_cycle", {31'd0, bus.err}, 32'd0);
    do_write(32'd1020, 2'b10, 32'hDEAD_BEEF, e);
    check("wr_below_base_err", {31'd0, e}, 32'd1);
    do_read(32'd1024, 2'b10, 1'b0, rd, e, lat);
    check("rd_after_bad_wr", rd, 32'h1122_BEEF);
    check("rd_after_bad_wr_err", {31'd0, e}, 32'd0);

    do_write(32'd2044, 2'b10, 32'hCAFE_F00D, e);
    check("wr_last_word_err", {31'd0, e}, 32'd0);
    do_read(32'd2047, 2'b00, 1'b1, rd, e, lat);
    check("rd_last_byte", rd, 32'h0000_000D);

    do_read(32'd2048, 2'b10, 1'b0, rd, e, lat);
    check("rd_oor_data", rd, 32'h0000_0000);
    check("rd_oor_err", {31'd0, e}, 32'd1);
    check("rd_oor_lat", lat, 2);
    do_read(32'd1024, 2'b11, 1'b0, rd, e, lat);
    check("rd_size11_err", {31'd0, e}, 32'd1);
    do_read(32'd1024, 2'b10, 1'b0, rd, e, lat);
    do_read(32'd1025, 2'b01, 1'b0, rd, e, lat);
    check("rd_half_odd_data", rd, 32'h0000_0000);
    check("rd_half_odd_err", {31'd0, e}, 32'd1);
    repeat (3) tick();
    check("rdata_hold", bus.rdata, 32'h0000_0000);

    wait_ready();
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'd1024; bus.size = 2'b10;
    tick();
    bus.req = 1'b0;
    rst = 1'b0;
    #1;
    check("midrd_rst_ready", {31'd0, bus.ready}, 32'd0);
    tick();
    rst = 1'b1;
    busy = 0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (bus.rvalid !== 1'b0 || bus.ready !== 1'b0 || bus.init_done !== 1'b0) busy++;
    end
    check("midrd_sweep_quiet", busy, 0);
    tick();
    check("midrd_resweep_ready", {31'd0, bus.ready}, 32'd1);
    do_read(32'd1024, 2'b10, 1'b0, rd, e, lat);
    check("midrd_cleared", rd, 32'h0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
